// File: rtl/cmlk_gate_scan_scheduler.sv
// cmlk_gate_scan_scheduler
//   Per-frame gate delay sequencer for the CMLK timing generator. On each CMOS
//   frame start it issues the gate A/B delays, the laser enable and a
//   background-frame flag. It sweeps the delays in M steps of delta_t, and
//   every N frames it inserts one laser-off background frame.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   enable              : level, 1 = scanning allowed
//   frame_start         : 1-cycle pulse per CMOS frame
//   cfg_update          : 1-cycle pulse, captures cfg inputs into the shadow set
//   base_delay_a/b      : start delays (ticks)
//   tim_cycles_m        : steps per scan (0 behaves as 1)
//   delay_step_delta_t  : delay increment per step
//   bg_frame_deci_n     : background frame every N frames (0 = never)
//   gate_delay_a/b_o    : delays for the current frame
//   step_idx_o          : step index of the current frame
//   laser_en_o          : fire laser this frame
//   bg_frame_o          : current frame is a background frame
//   scan_done_o         : 1-cycle pulse when the last step of a scan is issued
//   busy_o              : high while armed or running
module cmlk_gate_scan_scheduler #(
  parameter logic [31:0] MAX_DELAY = 32'd999_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        cfg_update,
  input  logic [31:0] base_delay_a,
  input  logic [31:0] base_delay_b,
  input  logic [7:0]  tim_cycles_m,
  input  logic [7:0]  delay_step_delta_t,
  input  logic [15:0] bg_frame_deci_n,
  output logic [31:0] gate_delay_a_o,
  output logic [31:0] gate_delay_b_o,
  output logic [7:0]  step_idx_o,
  output logic        laser_en_o,
  output logic        bg_frame_o,
  output logic        scan_done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] sh_base_a_q, sh_base_a_d, sh_base_b_q, sh_base_b_d;
  logic [7:0]  sh_m_q, sh_m_d, sh_dt_q, sh_dt_d;
  logic [15:0] sh_n_q, sh_n_d;
  logic [31:0] act_base_a_q, act_base_a_d, act_base_b_q, act_base_b_d;
  logic [7:0]  act_m_q, act_m_d, act_dt_q, act_dt_d;
  logic [15:0] act_n_q, act_n_d;
  logic [31:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [7:0]  step_q, step_d;
  logic [15:0] bg_cnt_q, bg_cnt_d;
  logic [31:0] gate_a_q, gate_a_d, gate_b_q, gate_b_d;
  logic [7:0]  step_idx_q, step_idx_d;
  logic        laser_en_q, laser_en_d, bg_frame_q, bg_frame_d;
  logic        scan_done_q, scan_done_d, busy_q, busy_d;

  logic [7:0]  last_step;
  logic        bg_hit;

  // 33-bit sum so the increment can never wrap before saturating.
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [7:0] dt);
    logic [32:0] sum;
    sum = {1'b0, acc} + {25'd0, dt};
    return (sum > {1'b0, MAX_DELAY}) ? MAX_DELAY : sum[31:0];
  endfunction

  assign last_step = (act_m_q == 8'd0) ? 8'd0 : act_m_q - 8'd1;
  assign bg_hit    = (act_n_q != 16'd0) && (bg_cnt_q == act_n_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    // Shadow write happens first so a same-cycle wrap copies the new values.
    sh_base_a_d  = cfg_update ? base_delay_a       : sh_base_a_q;
    sh_base_b_d  = cfg_update ? base_delay_b       : sh_base_b_q;
    sh_m_d       = cfg_update ? tim_cycles_m       : sh_m_q;
    sh_dt_d      = cfg_update ? delay_step_delta_t : sh_dt_q;
    sh_n_d       = cfg_update ? bg_frame_deci_n    : sh_n_q;
    act_base_a_d = act_base_a_q;
    act_base_b_d = act_base_b_q;
    act_m_d      = act_m_q;
    act_dt_d     = act_dt_q;
    act_n_d      = act_n_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    step_d       = step_q;
    bg_cnt_d     = bg_cnt_q;
    gate_a_d     = gate_a_q;
    gate_b_d     = gate_b_q;
    step_idx_d   = step_idx_q;
    laser_en_d   = laser_en_q;
    bg_frame_d   = bg_frame_q;
    scan_done_d  = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        laser_en_d = 1'b0;
        bg_frame_d = 1'b0;
        busy_d     = 1'b0;
        if (enable) begin
          act_base_a_d = sh_base_a_d;
          act_base_b_d = sh_base_b_d;
          act_m_d      = sh_m_d;
          act_dt_d     = sh_dt_d;
          act_n_d      = sh_n_d;
          acc_a_d      = sh_base_a_d;
          acc_b_d      = sh_base_b_d;
          step_d       = 8'd0;
          bg_cnt_d     = 16'd0;
          busy_d       = 1'b1;
          state_d      = ARM;
        end
      end
      ARM, RUN: begin
        if (!enable) begin
          // A frame_start coinciding with the enable drop is ignored.
          laser_en_d = 1'b0;
          bg_frame_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else if (frame_start) begin
          state_d = RUN;
          if (bg_hit) begin
            bg_frame_d = 1'b1;
            laser_en_d = 1'b0;
            bg_cnt_d   = 16'd0;
          end else begin
            bg_cnt_d   = (act_n_q == 16'd0) ? 16'd0 : bg_cnt_q + 16'd1;
            bg_frame_d = 1'b0;
            laser_en_d = 1'b1;
            gate_a_d   = acc_a_q;
            gate_b_d   = acc_b_q;
            step_idx_d = step_q;
            if (step_q == last_step) begin
              scan_done_d  = 1'b1;
              step_d       = 8'd0;
              act_base_a_d = sh_base_a_d;
              act_base_b_d = sh_base_b_d;
              act_m_d      = sh_m_d;
              act_dt_d     = sh_dt_d;
              act_n_d      = sh_n_d;
              acc_a_d      = sh_base_a_d;
              acc_b_d      = sh_base_b_d;
            end else begin
              step_d  = step_q + 8'd1;
              acc_a_d = sat_add(acc_a_q, act_dt_q);
              acc_b_d = sat_add(acc_b_q, act_dt_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_base_a_q  <= '0;
      sh_base_b_q  <= '0;
      sh_m_q       <= '0;
      sh_dt_q      <= '0;
      sh_n_q       <= '0;
      act_base_a_q <= '0;
      act_base_b_q <= '0;
      act_m_q      <= '0;
      act_dt_q     <= '0;
      act_n_q      <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      step_q       <= '0;
      bg_cnt_q     <= '0;
      gate_a_q     <= '0;
      gate_b_q     <= '0;
      step_idx_q   <= '0;
      laser_en_q   <= 1'b0;
      bg_frame_q   <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_base_a_q  <= sh_base_a_d;
      sh_base_b_q  <= sh_base_b_d;
      sh_m_q       <= sh_m_d;
      sh_dt_q      <= sh_dt_d;
      sh_n_q       <= sh_n_d;
      act_base_a_q <= act_base_a_d;
      act_base_b_q <= act_base_b_d;
      act_m_q      <= act_m_d;
      act_dt_q     <= act_dt_d;
      act_n_q      <= act_n_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      step_q       <= step_d;
      bg_cnt_q     <= bg_cnt_d;
      gate_a_q     <= gate_a_d;
      gate_b_q     <= gate_b_d;
      step_idx_q   <= step_idx_d;
      laser_en_q   <= laser_en_d;
      bg_frame_q   <= bg_frame_d;
      scan_done_q  <= scan_done_d;
      busy_q       <= busy_d;
    end
  end

  assign gate_delay_a_o = gate_a_q;
  assign gate_delay_b_o = gate_b_q;
  assign step_idx_o     = step_idx_q;
  assign laser_en_o     = laser_en_q;
  assign bg_frame_o     = bg_frame_q;
  assign scan_done_o    = scan_done_q;
  assign busy_o         = busy_q;

endmodule

// File: doc/cmlk_gate_scan_scheduler.md
# cmlk_gate_scan_scheduler

Sequences the per-frame gate timing of the CMLK timing generator. It takes the clamped parameter set as input: base gate delays A/B, step count M, step size delta_t and background decimation N. On every CMOS frame start it issues the frame's gate delays, the laser enable and a background-frame flag. It sweeps the gate delays in M steps of delta_t and inserts one laser-off background frame every N frames. It sits between the parameter clamp stage and the gate/laser pulse generators, and it is their only source of per-frame delay values.

## Interface
Parameters:
- MAX_DELAY, 999_999_999, saturation bound for the generated gate delays A/B.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  level; 1 = scanning allowed, 0 = stop.
- frame_start  in  1  one-cycle pulse at each CMOS frame start.
- cfg_update  in  1  one-cycle pulse; captures all cfg inputs into the shadow set.
- base_delay_a  in  32  clamped start delay, gate A (ticks).
- base_delay_b  in  32  clamped start delay, gate B (ticks).
- tim_cycles_m  in  8  steps per scan; 0 is treated as 1.
- delay_step_delta_t  in  8  delay increment per step (ticks).
- bg_frame_deci_n  in  16  background frame every N frames; 0 = no background frames.
- gate_delay_a_o  out  32  gate A delay for the current frame.
- gate_delay_b_o  out  32  gate B delay for the current frame.
- step_idx_o  out  8  step index of the current frame.
- laser_en_o  out  1  1 = fire laser this frame.
- bg_frame_o  out  1  1 = current frame is a background frame.
- scan_done_o  out  1  one-cycle pulse when the last step of a scan is issued.
- busy_o  out  1  1 while in ARM or RUN.

## Operation
- Shadow set:
  - Registered on cfg_update.
  - Holds base_delay_a/b, M, delta_t and N.
  - Reset value is all 0.
- Active set:
  - Copied from the shadow set only at IDLE->ARM and at a scan wrap.
  - Parameters never change mid-scan.
- Internal registers:
  - acc_a, acc_b: 32-bit delays for the next laser frame.
  - step: 8 bits.
  - bg_cnt: 16 bits.
- States:
  - IDLE: outputs hold, laser_en_o = 0. On enable=1: load the active set, acc = base, step = 0, bg_cnt = 0, go to ARM.
  - ARM: wait for frame_start, then handle that frame as in RUN and go to RUN.
  - RUN: act on each frame_start.
- Frame decision, taken on frame_start in ARM or RUN:
  - Background frame, when N != 0 and bg_cnt == N-1: bg_frame_o = 1, laser_en_o = 0, bg_cnt = 0. Delays, step_idx_o, acc and step are unchanged.
  - Laser frame, otherwise: bg_cnt increments (held at 0 when N = 0), bg_frame_o = 0, laser_en_o = 1, gate_delay_a/b_o = acc_a/b, step_idx_o = step.
- Stepping, after a laser frame:
  - Last step (step == M-1, with M = 0 treated as 1): scan_done_o pulses, step = 0, the shadow set is copied to active, acc = new base.
  - Otherwise: step increments, acc_x = min(acc_x + delta_t, MAX_DELAY).
  - The sum is computed at 33 bits, so it never wraps.
- The background frame count runs continuously across scan wraps; it is not reset at a wrap.
- Leaving a run:
  - enable = 0 in ARM or RUN: next cycle go to IDLE, laser_en_o = 0, bg_frame_o = 0, busy_o = 0.
  - Delays and step_idx_o hold their last values.
  - Re-enabling restarts from step 0 using the shadow set.

## Timing
- Reset values: gate_delay_a_o, gate_delay_b_o, step_idx_o, laser_en_o, bg_frame_o, scan_done_o and busy_o are all 0; state = IDLE.
- All outputs are registered.
- Frame outputs and scan_done_o become valid 1 cycle after frame_start and hold until the next frame_start (scan_done_o is high for 1 cycle only).
- busy_o rises 1 cycle after enable rises.
- frame_start during IDLE or in the enable-rise cycle: ignored.
- cfg_update in the same cycle as a wrap: the new values are used by that wrap (shadow write has priority, then the copy).
- enable falling in the same cycle as frame_start: that frame is ignored and the block goes to IDLE.
- rst mid-scan: all state returns to reset values on the next edge; shadow is cleared.

## Test plan
- Sweep: base_a = 100, base_b = 200, M = 4, delta = 10, N = 0, 6 frame_starts -> gate_delay_a_o = 100, 110, 120, 130, 100, 110; gate_delay_b_o = 200..230; scan_done_o pulses after the 4th frame; laser_en_o = 1 throughout.
- Background: M = 2, delta = 5, base_a = 0, N = 3, 7 frame_starts -> bg_frame_o = 0,0,1,0,0,1,0; gate_delay_a_o = 0,5,5,0,5,5,0; laser_en_o is 0 exactly on bg frames.
- Saturation: base_a = 999_999_990, delta = 8, M = 4 -> gate_delay_a_o = 999_999_990, 999_999_998, 999_999_999, 999_999_999.
- Deferred update: M = 3; cfg_update with base_a = 500 at frame 2 -> frames 2 and 3 keep the old sweep; frame 4 = 500. Also repeat with cfg_update coincident with the wrap frame_start.
- Stop/restart: drop enable after frame 2, pulse frame_start -> no output change, laser_en_o = 0, busy_o = 0; re-enable -> first frame uses the base delays at step_idx_o = 0.
- Reset mid-RUN: assert rst for 1 cycle -> all outputs 0, IDLE; the next frame_start has no effect until enable is re-asserted.
